seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display_pkg.sv | 28 ++
 rtl/seg_scan_display_decode.sv | 29 ++
 rtl/seg_scan_display.sv | 134 +++++++++++++
 tb/tb_seg_scan_display.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_display_pkg.sv
// Shared constants and types for the multiplexed 7-segment scanner.
// Segment bytes are ordered {a,b,c,d,e,f,g,dp}, active-high.
package seg_scan_display_pkg;

    localparam int unsigned SCAN_DIV_DEFAULT  = 100_000;
    localparam int unsigned BLINK_DIV_DEFAULT = 50_000_000;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Registered display outputs, kept together so they update as one word.
    typedef struct packed {
        logic [7:0] digit1;
        logic [7:0] digit2;
        logic [7:0] tube_sel;
    } disp_out_t;

endpackage

// File: rtl/seg_scan_display_decode.sv
// seg_decode: combinational nibble-to-segment decoder.
// Ports: code (4-bit digit code) -> seg (8-bit {a..g,dp}, active-high).
// Codes 0-9 are digits, F is a dash, A-E are blank.
module seg_decode
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hF:    seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: eight-tube multiplexed 7-segment scanner with blinking.
// Ports:
//   clk, rst (synchronous, active-low)
//   time_data  : eight 4-bit codes, [31:28] is the leftmost tube
//   blink_en   : enables blinking of tubes selected by blink_mask
//   blink_mask : bit i blinks the tube driven by tube_sel[i]
//   digit1     : segments for tubes 7..4 (zero while scanning tubes 3..0)
//   digit2     : segments for tubes 3..0 (zero while scanning tubes 7..4)
//   tube_sel   : one-hot tube enable, bit 7 is the leftmost tube
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter int unsigned BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] time_data,
    input  logic        blink_en,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    if (CLK_HZ == 0 || SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
        $error("seg_scan_display: CLK_HZ must be nonzero, SCAN_DIV and BLINK_DIV at least 2");
    end

    logic [SCAN_W-1:0]  scan_cnt, scan_cnt_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_nxt;
    logic               phase, phase_nxt;
    logic               loaded, loaded_nxt;
    logic [31:0]        shadow, shadow_nxt;
    disp_out_t          disp, disp_nxt;

    logic [2:0]  tube;
    logic [31:0] frame_src;
    logic [3:0]  code;
    logic [7:0]  seg;
    logic [7:0]  seg_vis;

    // Slot idx drives tube 7-idx, so the scan runs left to right.
    assign tube = 3'd7 - idx;

    // The first cycle out of reset displays time_data directly while the
    // shadow captures it, so the first frame is already the live sample.
    assign frame_src = loaded ? shadow : time_data;
    assign code      = 4'(frame_src >> {tube, 2'b00});

    seg_decode u_decode (
        .code (code),
        .seg  (seg)
    );

    // Next-state and next-output logic.
    always_comb begin
        scan_cnt_nxt  = scan_cnt + SCAN_W'(1);
        idx_nxt       = idx;
        shadow_nxt    = shadow;
        loaded_nxt    = 1'b1;
        blink_cnt_nxt = '0;
        phase_nxt     = 1'b1;
        seg_vis       = seg;
        disp_nxt      = '0;

        if (!loaded) begin
            shadow_nxt = time_data;
        end

        // Frame boundary: the shadow reloads as idx wraps 7 -> 0.
        if (scan_cnt == SCAN_LAST) begin
            scan_cnt_nxt = '0;
            idx_nxt      = idx + 3'd1;
            if (idx == 3'd7) begin
                shadow_nxt = time_data;
            end
        end

        // Disabling blink parks the phase visible so re-enabling starts visible.
        if (blink_en) begin
            blink_cnt_nxt = blink_cnt + BLINK_W'(1);
            phase_nxt     = phase;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt = '0;
                phase_nxt     = ~phase;
            end
        end

        if (blink_en && !phase && blink_mask[tube]) begin
            seg_vis = SEG_BLANK;
        end

        disp_nxt.tube_sel = 8'd1 << tube;
        if (idx[2]) begin
            disp_nxt.digit2 = seg_vis;
        end else begin
            disp_nxt.digit1 = seg_vis;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            loaded    <= 1'b0;
            shadow    <= '0;
            disp      <= '0;
        end else begin
            scan_cnt  <= scan_cnt_nxt;
            idx       <= idx_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
            loaded    <= loaded_nxt;
            shadow    <= shadow_nxt;
            disp      <= disp_nxt;
        end
    end

    assign digit1   = disp.digit1;
    assign digit2   = disp.digit2;
    assign tube_sel = disp.tube_sel;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with SCAN_DIV=4, BLINK_DIV=16.
module tb_seg_scan_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int FRAME     = 8 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] time_data;
    logic        blink_en;
    logic [7:0]  blink_mask;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  tube_sel;

    int checks = 0;
    int passed = 0;

    seg_scan_display #(
        .CLK_HZ    (100_000_000),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .time_data  (time_data),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .digit1     (digit1),
        .digit2     (digit2),
        .tube_sel   (tube_sel)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Segment patterns drawn from the letters lit for each glyph.
    function automatic logic [7:0] ref_seg(input logic [3:0] c);
        case (c)
            4'h0: return 8'hFC;  // a b c d e f
            4'h1: return 8'h60;  // b c
            4'h2: return 8'hDA;  // a b d e g
            4'h3: return 8'hF2;  // a b c d g
            4'h4: return 8'h66;  // b c f g
            4'h5: return 8'hB6;  // a c d f g
            4'h6: return 8'hBE;  // a c d e f g
            4'h7: return 8'hE0;  // a b c
            4'h8: return 8'hFE;  // all but dp
            4'h9: return 8'hF6;  // a b c d f g
            4'hF: return 8'h02;  // g
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural model: n counts edges since reset release; slot and frame
    // follow from n arithmetically; m counts consecutive blink-enabled edges.
    int          n = 0;
    int          m = 0;
    int          slot;
    int          tube;
    bit          model_ok = 1'b0;
    bit          pend_ok = 1'b0;
    logic [31:0] frame_val = '0;
    logic [31:0] pend = '0;
    logic [7:0]  mseg;
    logic [7:0]  e_d1 = '0;
    logic [7:0]  e_d2 = '0;
    logic [7:0]  e_ts = '0;

    always @(posedge clk) begin
        if (!rst) begin
            n = 0; m = 0; pend_ok = 1'b0;
            e_d1 = '0; e_d2 = '0; e_ts = '0;
            model_ok = 1'b1;
        end else begin
            n++;
            if (n == 1) frame_val = time_data;
            else if (pend_ok) begin frame_val = pend; pend_ok = 1'b0; end
            slot = ((n - 1) / SCAN_DIV) % 8;
            tube = 7 - slot;
            mseg = ref_seg(4'((frame_val >> (4 * tube)) & 32'hF));
            if (blink_en && blink_mask[tube] && ((m / BLINK_DIV) % 2 == 1)) mseg = 8'h00;
            e_ts = 8'(1 << tube);
            e_d1 = (slot < 4) ? mseg : 8'h00;
            e_d2 = (slot < 4) ? 8'h00 : mseg;
            // Next frame shows time_data as seen on the last edge of this one.
            if (n % FRAME == 0) begin pend = time_data; pend_ok = 1'b1; end
            m = blink_en ? m + 1 : 0;
        end
    end

    // Per-cycle comparison against the model, plus the one-hot property.
    always @(negedge clk) begin
        if (model_ok) begin
            chk8("model_tube_sel", tube_sel, e_ts);
            chk8("model_digit1", digit1, e_d1);
            chk8("model_digit2", digit2, e_d2);
            chk1("tube_sel_onehot0", $onehot0(tube_sel), 1'b1);
        end
    end

    logic [7:0] fr_ts [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] fr_d1 [8] = '{8'h60, 8'hDA, 8'h02, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] fr_d2 [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h66, 8'h02, 8'hB6, 8'hBE};

    initial begin
        rst        = 1'b0;
        time_data  = 32'h12F34F56;
        blink_en   = 1'b0;
        blink_mask = 8'h00;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk8("rst_tube_sel", tube_sel, 8'h00);
            chk8("rst_digit1", digit1, 8'h00);
            chk8("rst_digit2", digit2, 8'h00);
        end

        // Release: first edge shows leftmost tube of the live sample.
        rst = 1'b1;
        tick();
        chk8("rel_tube_sel", tube_sel, 8'h80);
        chk8("rel_digit1", digit1, 8'h60);
        chk8("rel_digit2", digit2, 8'h00);

        // Rest of the first frame, edges 2..32.
        for (int k = 2; k <= 32; k++) begin
            tick();
            chk8("frame_tube_sel", tube_sel, fr_ts[(k - 1) / 4]);
            chk8("frame_digit1", digit1, fr_d1[(k - 1) / 4]);
            chk8("frame_digit2", digit2, fr_d2[(k - 1) / 4]);
        end

        // Tear: change data during slot 3 of the second frame (edges 45..48).
        repeat (13) tick();
        time_data = 32'h98765432;
        repeat (4) tick();
        chk8("tear_slot4_ts", tube_sel, 8'h08);
        chk8("tear_slot4_d2", digit2, 8'h66);
        repeat (15) tick();
        chk8("tear_slot7_ts", tube_sel, 8'h01);
        chk8("tear_slot7_d2", digit2, 8'hBE);
        tick();
        chk8("new_slot0_ts", tube_sel, 8'h80);
        chk8("new_slot0_d1", digit1, 8'hF6);
        repeat (4) tick();
        chk8("new_slot1_ts", tube_sel, 8'h40);
        chk8("new_slot1_d1", digit1, 8'hFE);

        // Blink from edge 80: visible 80..95, blank 96..111.
        repeat (10) tick();
        blink_en   = 1'b1;
        blink_mask = 8'h03;
        repeat (11) tick();
        chk8("blink_vis_t1_ts", tube_sel, 8'h02);
        chk8("blink_vis_t1_d2", digit2, 8'hF2);
        repeat (5) tick();
        chk8("blink_vis_t0_d2", digit2, 8'hDA);
        tick();
        chk8("blink_off_t0_ts", tube_sel, 8'h01);
        chk8("blink_off_t0_d2", digit2, 8'h00);
        repeat (4) tick();
        chk8("blink_unmasked_ts", tube_sel, 8'h80);
        chk8("blink_unmasked_d1", digit1, 8'hF6);

        // Blank code B on the leftmost tube, then reset in the middle of slot 5.
        blink_en  = 1'b0;
        time_data = 32'hB0000000;
        repeat (29) tick();
        chk8("code_b_ts", tube_sel, 8'h80);
        chk8("code_b_d1", digit1, 8'h00);
        repeat (21) tick();
        chk8("slot5_ts", tube_sel, 8'h04);
        chk8("slot5_d2", digit2, 8'hFC);
        rst = 1'b0;
        tick();
        chk8("midrst_tube_sel", tube_sel, 8'h00);
        chk8("midrst_digit2", digit2, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        chk8("rel2_tube_sel", tube_sel, 8'h80);
        chk8("rel2_digit1", digit1, 8'h00);
        repeat (20) tick();
        time_data = 32'h0123456F;
        repeat (50) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
